regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port register file for the MIPS datapath. Configurable read/write port counts,
//   optional hardwired-zero entry, and a hardware clear sequencer that zeroes every entry after reset.
//   Sits between decode (read addresses) and writeback (write ports). Read ports serve
//   operand fetch; write ports serve writeback.
// PARAMETERS
//   WIDTH       32  data width of each entry
//   ADDR_WIDTH  5   address width; DEPTH = 1<<ADDR_WIDTH entries
//   NREAD       2   number of read ports, 1..4
//   NWRITE      1   number of write ports, 1..2
//   ZERO_REG    1   1: entry 0 always reads 0 and ignores writes; 0: entry 0 is ordinary
// PORTS
//   clk        in   1                  clock, all state updates on posedge
//   reset      in   1                  synchronous, active-low reset (0 = reset)
//   regWrite   in   NWRITE             per-port write enable
//   writeAddr  in   NWRITE*ADDR_WIDTH  flattened write addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   writeData  in   NWRITE*WIDTH       flattened write data, port p at [p*WIDTH +: WIDTH]
//   readAddr   in   NREAD*ADDR_WIDTH   flattened read addresses
//   readData   out  NREAD*WIDTH        flattened read data, combinational
//   ready      out  1                  1 once clear sequence done; registered
// BEHAVIOUR
//   - FSM states: CLEAR, RUN. Sampled reset==0 -> state=CLEAR, clr_ptr=0, ready=0 (reset values).
//   - CLEAR: each cycle with reset==1: MEM[clr_ptr]<=0, clr_ptr<=clr_ptr+1. Cycle that writes DEPTH-1 -> state=RUN,
//     ready<=1 same edge. First edge with reset==1 clears entry 0, so ready rises exactly DEPTH edges after reset deasserts.
//   - Reset asserted mid-CLEAR or in RUN: restarts at CLEAR, clr_ptr=0, ready=0; previously written data is
//     lost (cleared again).
//   - During CLEAR: regWrite ignored on all ports; all readData = 0 regardless of memory contents.
//   - RUN: on posedge, port p with regWrite[p]=1 writes MEM[writeAddr_p] <= writeData_p.
//   - Same-address writes on both ports same cycle: port 1 (higher index) wins; port 0 write is dropped.
//   - ZERO_REG=1: writes to address 0 are discarded; readData for address 0 = 0 always.
//   - Reads: readData_r = MEM[readAddr_r], combinational, zero latency; write visible on the cycle after the edge.
//   - Any number of read ports may read the same address; no read-side conflicts exist.
//   - clr_ptr is ADDR_WIDTH bits; wrap from DEPTH-1 to 0 never used (FSM leaves CLEAR first).
// CONFIGURATION
//   REGFILE_BYPASS_EN defined: write-to-read forwarding in RUN. If regWrite[p]=1 and writeAddr_p==readAddr_r
//     (and not a ZERO_REG discard), readData_r = writeData_p in that same cycle; port 1 beats port 0 (same
//     priority as the write). No effect during CLEAR (reads still 0).
//   Undefined: reads return stored MEM contents only; written value appears on the cycle after the edge.
// STRUCTURE
//   regfile_pkg: FSM state typedef (CLEAR/RUN), constant for the DEPTH expression, helper function for
//     ZERO_REG discard test.
//   Sub-module regfile_clear_seq: clear FSM, clr_ptr counter, ready flag; outputs clr_we/clr_addr into the array.
//   Top regfile_mp: storage array, write-port priority mux, read muxes, optional bypass logic.
// TESTING
//   1. reset=0 for 2 cycles then 1, ADDR_WIDTH=5 -> ready=0 for 32 edges, ready=1 on 32nd; all reads 0 after.
//   2. In CLEAR, regWrite=1 addr 8 data 32'hdeadbeef -> after ready, read addr 8 = 0.
//   3. RUN, port0 write addr 9 = 32'h12345678 -> readData for addr 9 = 32'h12345678 on next cycle, all NREAD ports agree.
//   4. NWRITE=2, both ports write addr 10 (0x1111 / 0x2222) -> addr 10 reads 0x2222.
//   5. ZERO_REG=1, write addr 0 = 32'hffffffff -> read addr 0 = 0; ZERO_REG=0 -> reads 32'hffffffff.
//   6. REGFILE_BYPASS_EN: write addr 11 = 0xabcd while reading 11 -> readData=0xabcd same cycle (old value without macro);
//      assert reset mid-CLEAR at ptr 17 -> ready rises 32 edges after reset deasserts.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: clear-FSM state type, depth and zero-entry helpers shared by the register file
package regfile_pkg;
  typedef enum logic {CLEAR, RUN} state_t;
  function automatic int depthOf(input int addrWidth);
    return 1 << addrWidth;
  endfunction
  function automatic logic isDiscard(input logic zeroReg, input logic [31:0] addr);
    return zeroReg && addr == '0;
  endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write port bundle for regfile_mp
interface regfile_mp_if #(
  parameter int WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NREAD = 2,
  parameter int NWRITE = 1
);
  logic [NWRITE-1:0] regWrite;
  logic [NWRITE*ADDR_WIDTH-1:0] writeAddr;
  logic [NWRITE*WIDTH-1:0] writeData;
  logic [NREAD*ADDR_WIDTH-1:0] readAddr;
  logic [NREAD*WIDTH-1:0] readData;
  logic ready;
  modport master(output regWrite, writeAddr, writeData, readAddr, input readData, ready);
  modport slave(input regWrite, writeAddr, writeData, readAddr, output readData, ready);
endinterface

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: after reset, walks every entry once to zero it, then raises ready
module regfile_clear_seq import regfile_pkg::*; #(
  parameter int ADDR_WIDTH = 5
) (
  input logic clk,
  input logic reset,
  output logic clrWe,
  output logic [ADDR_WIDTH-1:0] clrAddr,
  output logic ready
);
  state_t state, nextState;
  logic [ADDR_WIDTH-1:0] clrPtr;
  always_ff @(posedge clk)
    if (!reset) begin
      state <= CLEAR;
      clrPtr <= '0;
      ready <= 1'b0;
    end else begin
      state <= nextState;
      clrPtr <= state == CLEAR ? clrPtr + 1'b1 : clrPtr;
      ready <= nextState == RUN;
    end
  always_comb nextState = (state == CLEAR && (&clrPtr)) ? RUN : state;
  always_comb begin
    clrWe = state == CLEAR;
    clrAddr = clrPtr;
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with optional hardwired-zero entry and post-reset clear
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto matching reads.
module regfile_mp import regfile_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NREAD = 2,
  parameter int NWRITE = 1,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic reset,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = depthOf(ADDR_WIDTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wa [NWRITE];
  logic [WIDTH-1:0] wd [NWRITE];
  logic [ADDR_WIDTH-1:0] ra [NREAD];
  logic clrWe, ready;
  logic [ADDR_WIDTH-1:0] clrAddr;
  regfile_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr (
    .clk(clk),
    .reset(reset),
    .clrWe(clrWe),
    .clrAddr(clrAddr),
    .ready(ready)
  );
  assign bus.ready = ready;
  for (genvar p = 0; p < NWRITE; p++) begin : g_wr
    assign wa[p] = bus.writeAddr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign wd[p] = bus.writeData[p*WIDTH +: WIDTH];
  end
  // Ascending port order makes the higher-index port win a same-address collision.
  always_ff @(posedge clk)
    if (clrWe) mem[clrAddr] <= '0;
    else if (reset)
      for (int p = 0; p < NWRITE; p++)
        if (bus.regWrite[p] && !isDiscard(ZERO_REG != 0, 32'(wa[p]))) mem[wa[p]] <= wd[p];
  for (genvar r = 0; r < NREAD; r++) begin : g_rd
    logic [WIDTH-1:0] val;
    assign ra[r] = bus.readAddr[r*ADDR_WIDTH +: ADDR_WIDTH];
    always_comb begin
      val = isDiscard(ZERO_REG != 0, 32'(ra[r])) ? '0 : mem[ra[r]];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NWRITE; p++)
        if (bus.regWrite[p] && wa[p] == ra[r] && !isDiscard(ZERO_REG != 0, 32'(wa[p]))) val = wd[p];
`endif
    end
    assign bus.readData[r*WIDTH +: WIDTH] = ready ? val : '0;
  end
endmodule
